// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider, plus a plain-arithmetic
// reference function returning the expected {remainder, quotient}.
package div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic DIV_SIGNED   = 1'b0;
   localparam logic DIV_UNSIGNED = 1'b1;

   // Valid for 1 <= width <= 63; result is {r[127:64], q[63:0]}, each masked to width.
   function automatic logic [127:0] div_ref(input logic [63:0] a, input logic [63:0] b,
                                            input logic mode, input int width);
      logic [63:0] mask;
      logic [63:0] q;
      logic [63:0] r;
      longint      sa;
      longint      sb;
      mask = (64'd1 << width) - 64'd1;
      if ((b & mask) == 64'd0) begin
         q = mask;
         r = a & mask;
      end else if (mode == DIV_UNSIGNED) begin
         q = (a & mask) / (b & mask);
         r = (a & mask) % (b & mask);
      end else begin
         sa = $signed(a << (64 - width)) >>> (64 - width);
         sb = $signed(b << (64 - width)) >>> (64 - width);
         q  = sa / sb;
         r  = sa % sb;
      end
      return {r & mask, q & mask};
   endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of an operand pair; used both to take
// magnitudes of the inputs and to restore the signs of quotient and remainder.
module div_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             neg_a,
   input  logic             neg_b,
   output logic [WIDTH-1:0] fix_a,
   output logic [WIDTH-1:0] fix_b
);

   // The most negative value maps to itself, which read as unsigned is its magnitude.
   assign fix_a = neg_a ? -a : a;
   assign fix_b = neg_b ? -b : b;

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, with start/busy/done
// handshake and registered results held until the next operation completes.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk_sig,
   input  logic             rst_sig,
   input  logic             ena_sig,
   input  logic             start,
   input  logic             sign_flag,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] q_out,
   output logic [WIDTH-1:0] r_out
);

   localparam int MSB = WIDTH - 1;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             mode_r;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] q_res;
   logic [WIDTH-1:0] r_res;

   logic             accept;
   logic             is_signed;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic [WIDTH:0]   rem_sh;
   logic             ge;
   logic [WIDTH-1:0] rem_nxt;

   assign is_signed = (sign_flag == DIV_SIGNED);
   assign accept    = (state == IDLE) && ena_sig && start;

   div_sign_fix #(.WIDTH(WIDTH)) u_pre (
      .a     (op_a),
      .b     (op_b),
      .neg_a (is_signed & op_a[MSB]),
      .neg_b (is_signed & op_b[MSB]),
      .fix_a (abs_a),
      .fix_b (abs_b)
   );

   div_sign_fix #(.WIDTH(WIDTH)) u_post (
      .a     (quo),
      .b     (rem),
      .neg_a (neg_q & (mode_r == DIV_SIGNED)),
      .neg_b (neg_r & (mode_r == DIV_SIGNED)),
      .fix_a (q_fix),
      .fix_b (r_fix)
   );

   // The partial remainder stays below the divisor, so the restored value fits in WIDTH bits.
   assign rem_sh  = {rem, quo[MSB]};
   assign ge      = (rem_sh >= {1'b0, divisor});
   assign rem_nxt = ge ? WIDTH'(rem_sh - {1'b0, divisor}) : rem_sh[MSB:0];

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      if (!ena_sig) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_sig or posedge rst_sig) begin
      if (rst_sig) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk_sig or posedge rst_sig) begin
      if (rst_sig) begin
         cnt      <= '0;
         mode_r   <= DIV_SIGNED;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         divisor  <= '0;
         rem      <= '0;
         quo      <= '0;
         q_res    <= '0;
         r_res    <= '0;
      end else if (accept) begin
         cnt      <= CNT_W'(WIDTH - 1);
         mode_r   <= sign_flag;
         neg_q    <= is_signed & (op_a[MSB] ^ op_b[MSB]);
         neg_r    <= is_signed & op_a[MSB];
         div_zero <= (op_b == '0);
         divisor  <= abs_b;
         rem      <= '0;
         quo      <= abs_a;
      end else if (ena_sig && state == CALC) begin
         cnt <= cnt - CNT_W'(1);
         rem <= rem_nxt;
         quo <= {quo[MSB-1:0], ge};
      end else if (ena_sig && state == FIX) begin
         q_res <= div_zero ? '1 : q_fix;
         r_res <= r_fix;
      end
   end

   assign busy  = (state == CALC) || (state == FIX);
   assign done  = (state == DONE);
   assign q_out = ena_sig ? q_res : '0;
   assign r_out = ena_sig ? r_res : '0;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed 32-bit vector table, handshake/abort/reset
// sequences, and random 8-bit operations against an arithmetic model.
module tb_seq_divider;

   localparam int W32 = 32;
   localparam int W8  = 8;

   logic clk;
   logic rst;

   logic        ena32, start32, mode32, busy32, done32, dz32;
   logic [31:0] a32, b32, q32, r32;
   logic        ena8, start8, mode8, busy8, done8, dz8;
   logic [7:0]  a8, b8, q8, r8;

   int n_tests = 0;
   int n_fail  = 0;
   int overlap = 0;

   seq_divider #(.WIDTH(W32)) dut32 (
      .clk_sig(clk), .rst_sig(rst), .ena_sig(ena32), .start(start32), .sign_flag(mode32),
      .op_a(a32), .op_b(b32), .busy(busy32), .done(done32), .div_zero(dz32),
      .q_out(q32), .r_out(r32)
   );

   seq_divider #(.WIDTH(W8)) dut8 (
      .clk_sig(clk), .rst_sig(rst), .ena_sig(ena8), .start(start8), .sign_flag(mode8),
      .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .div_zero(dz8),
      .q_out(q8), .r_out(r8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if ((busy32 && done32) || (busy8 && done8)) overlap++;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for the divider", name);
   endtask

   // Returns at a negedge with the 32-bit divider idle.
   task automatic wait_idle32();
      int n = 0;
      @(negedge clk);
      while ((busy32 || done32) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) timeout("idle32");
   endtask

   task automatic wait_idle8();
      int n = 0;
      @(negedge clk);
      while ((busy8 || done8) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) timeout("idle8");
   endtask

   // lat counts cycles from the accept edge: the cycle after it is cycle 1.
   task automatic run32(input logic mode, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat);
      wait_idle32();
      start32 = 1'b1; mode32 = mode; a32 = a; b32 = b;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0;
      lat = -1;
      for (int k = 1; k <= W32 + 20; k++) begin
         @(posedge clk);
         #1;
         if (done32) begin
            lat = k + 1;
            break;
         end
      end
      q = q32; r = r32; dz = dz32;
   endtask

   task automatic run8(input logic mode, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic dz,
                       output int lat);
      wait_idle8();
      start8 = 1'b1; mode8 = mode; a8 = a; b8 = b;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      lat = -1;
      for (int k = 1; k <= W8 + 20; k++) begin
         @(posedge clk);
         #1;
         if (done8) begin
            lat = k + 1;
            break;
         end
      end
      q = q8; r = r8; dz = dz8;
   endtask

   function automatic void model8(input logic mode, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r);
      int sa;
      int sb;
      if (b == 8'd0) begin
         q = 8'hFF;
         r = a;
      end else if (mode) begin
         q = 8'(int'(a) / int'(b));
         r = 8'(int'(a) % int'(b));
      end else begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         q  = 8'(sa / sb);
         r  = 8'(sa % sb);
      end
   endfunction

   typedef struct {
      logic        mode;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [31:0] q, r, prev_q, prev_r;
      logic [7:0]  q8v, r8v, eq8, er8, ra, rb;
      logic        dz, rm;
      int          lat, dones;
      bit          seen;

      vecs[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      vecs[2]  = '{1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
      vecs[3]  = '{1'b0, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
      vecs[4]  = '{1'b1, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
      vecs[5]  = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
      vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
      vecs[7]  = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[8]  = '{1'b0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
      vecs[9]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
      vecs[10] = '{1'b0, 32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};

      rst = 1'b1;
      ena32 = 1'b1; start32 = 1'b0; mode32 = 1'b0; a32 = '0; b32 = '0;
      ena8  = 1'b1; start8  = 1'b0; mode8  = 1'b0; a8  = '0; b8  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {busy32, done32, dz32, q32, r32}, '0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      for (int i = 0; i < 11; i++) begin
         run32(vecs[i].mode, vecs[i].a, vecs[i].b, q, r, dz, lat);
         check($sformatf("vec%0d_q", i), q, vecs[i].q);
         check($sformatf("vec%0d_r", i), r, vecs[i].r);
         check($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
         check($sformatf("vec%0d_latency", i), lat, W32 + 2);
      end
      prev_q = 32'd333;
      prev_r = 32'd1;

      // start held high: one done, then re-accept one cycle after done
      wait_idle32();
      start32 = 1'b1; mode32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
      @(posedge clk);
      dones = 0;
      for (int k = 1; k <= W32 + 2; k++) begin
         @(posedge clk);
         #1;
         if (done32) dones++;
         if (k == W32 + 2) check("hs_idle_after_done", busy32, 1'b0);
      end
      check("hs_one_done", dones, 1);
      @(posedge clk);
      #1;
      check("hs_second_accept", busy32, 1'b1);
      @(negedge clk);
      start32 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < W32 + 10 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = done32;
      end
      check("hs_second_done", seen, 1'b1);
      check("hs_second_q", q32, 32'd10);
      check("hs_second_r", r32, 32'd0);
      prev_q = 32'd10;
      prev_r = 32'd0;

      // ena dropped at CALC iteration 10
      wait_idle32();
      start32 = 1'b1; mode32 = 1'b1; a32 = 32'd999; b32 = 32'd4;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("abort_busy_before", busy32, 1'b1);
      check("abort_q_held", q32, prev_q);
      @(negedge clk);
      ena32 = 1'b0;
      #1;
      check("abort_q_gated", q32, 32'd0);
      check("abort_r_gated", r32, 32'd0);
      @(posedge clk);
      #1;
      check("abort_busy_after", busy32, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < W32 + 5; k++) begin
         @(posedge clk);
         #1;
         if (done32) seen = 1'b1;
      end
      check("abort_no_done", seen, 1'b0);
      @(negedge clk);
      ena32 = 1'b1;
      #1;
      check("abort_results_kept", {q32, r32}, {prev_q, prev_r});

      // reset pulsed mid-CALC during a divide-by-zero
      wait_idle32();
      start32 = 1'b1; mode32 = 1'b0; a32 = 32'd77; b32 = 32'd0;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("rst_dz_before", dz32, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_outputs", {busy32, done32, dz32, q32, r32}, '0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < W32 + 5; k++) begin
         @(posedge clk);
         #1;
         if (done32) seen = 1'b1;
      end
      check("rst_no_done", seen, 1'b0);
      run32(1'b1, 32'd100, 32'd7, q, r, dz, lat);
      check("post_rst_qr", {q, r}, {32'd14, 32'd2});

      // Random 8-bit operations against the arithmetic model
      for (int i = 0; i < 2000; i++) begin
         rm = 1'($urandom_range(0, 1));
         ra = 8'($urandom);
         rb = (i % 40 == 0) ? 8'd0 : 8'($urandom);
         if (i % 97 == 5) begin
            rm = 1'b0; ra = 8'h80; rb = 8'hFF;
         end
         model8(rm, ra, rb, eq8, er8);
         run8(rm, ra, rb, q8v, r8v, dz, lat);
         check($sformatf("rnd%0d_q m=%0d a=%0h b=%0h", i, rm, ra, rb), q8v, eq8);
         check($sformatf("rnd%0d_r m=%0d a=%0h b=%0h", i, rm, ra, rb), r8v, er8);
         check($sformatf("rnd%0d_dz", i), dz, (rb == 8'd0));
         check($sformatf("rnd%0d_latency", i), lat, W8 + 2);
      end

      check("busy_done_never_together", overlap, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
